mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Downstream of the dcache and icache: arbitrates their word requests onto the single RAM port.
//  dcache has priority; a streak limit prevents icache starvation.
//  Produces the iwait/dwait/iload/dload handshake the caches consume and keeps per-requester transaction counts.
// PARAMETERS
//  MAX_DSTREAK  4   consecutive dcache grants allowed while iREN pending before icache is forced in
//  CNT_W        32  width of the statistics counters
// PORTS
//  CLK         in   1      clock, rising edge
//  RST         in   1      reset, asynchronous, active-high
//  iREN        in   1      icache read request
//  iaddr       in   32     icache word address
//  iwait       out  1      0 = iload valid / icache transfer done this cycle
//  iload       out  32     icache read data
//  dREN        in   1      dcache read request
//  dWEN        in   1      dcache write request
//  daddr       in   32     dcache word address
//  dstore      in   32     dcache write data
//  dwait       out  1      0 = dcache transfer done this cycle
//  dload       out  32     dcache read data
//  ramREN      out  1      RAM read strobe
//  ramWEN      out  1      RAM write strobe
//  ramaddr     out  32     RAM address
//  ramstore    out  32     RAM write data
//  ramload     in   32     RAM read data
//  ramstate    in   2      FREE=0, BUSY=1, ACCESS=2, ERROR=3
//  icount      out  CNT_W  completed icache transfers
//  dcount      out  CNT_W  completed dcache transfers
//  errcount    out  CNT_W  cycles in which ramstate==ERROR was seen while granted
// BEHAVIOUR
//  - Reset (async, RST=1): state=IDLE, dstreak=0, all counters 0.
//    Output values during reset:
//      ramREN=ramWEN=0, ramaddr=ramstore=0
//      iwait=dwait=1, iload=dload=0
//  - FSM states:
//    * IDLE: no RAM strobes; iwait=dwait=1.
//      Next-state selection, in priority order:
//        1. (iREN && dstreak==MAX_DSTREAK) -> ISERV
//        2. (dREN|dWEN)                    -> DSERV
//        3. iREN                           -> ISERV
//        4. otherwise                      -> IDLE
//    * DSERV: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN.
//      dWEN&dREN both high is treated as a write.
//    * ISERV: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
//  - Latency: request sampled in IDLE at cycle N; RAM strobes first asserted at cycle N+1.
//    Completion is ramstate==ACCESS while granted. In that cycle:
//      granted wait=0; granted load=ramload (combinational pass-through)
//      counter+1; next state=IDLE
//    Minimum 2 cycles per transfer, with one IDLE bubble between transfers.
//  - The non-granted requester always sees wait=1; its load output is 0.
//  - BUSY / FREE while granted: hold state; strobes and address stay stable; wait=1.
//  - ERROR while granted: errcount+1 (saturating); hold state and strobes, i.e. retry until ACCESS; wait stays 1.
//  - Requester withdraws mid-transfer (granted REN/WEN drops before ACCESS):
//    strobes drop in the same cycle (combinational); next state=IDLE; no counter increment.
//  - dstreak:
//    * +1 (saturating at MAX_DSTREAK) on each dcache completion while iREN=1.
//    * Cleared on any icache completion, and when a dcache completion occurs with iREN=0.
//  - Counters wrap modulo 2^CNT_W; errcount saturates at all-ones.
//  - Simultaneous iREN and dREN in IDLE with dstreak<MAX_DSTREAK: dcache wins; icache waits.
//  - Reset asserted mid-transfer: immediate return to reset values; the transfer is dropped, not counted.
// TESTING
//  1. Reset, then dREN=1 with daddr=0x40 and ramstate=BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF
//     -> ramREN at cycle 1; dwait=0 and dload=0xDEADBEEF only in the ACCESS cycle; dcount=1.
//  2. iREN and dWEN together, daddr=0x80, dstore=0x1234
//     -> dcache served first with ramWEN=1, ramstore=0x1234; then one IDLE cycle; then ISERV; icount=1, dcount=1.
//  3. iREN held high with continuous dREN, every RAM access 1 cycle
//     -> exactly 4 dcache completions, then 1 icache completion; pattern repeats.
//  4. DSERV with ramstate=ERROR 3 cycles then ACCESS
//     -> errcount=3; strobes/address unchanged throughout; single dwait=0 pulse; dcount=1.
//  5. dREN dropped during BUSY
//     -> ramREN=0 in that cycle; IDLE next; dcount unchanged; a following iREN is granted normally.
//  6. RST pulsed while in ISERV
//     -> all outputs at reset values asynchronously; icount=0; a new request after release is served from IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle of the memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    logic        iren;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramren;
    logic        ramwen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramren, ramwen, ramaddr, ramstore
    );

    modport master (
        output iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramren, ramwen, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache word requests onto one RAM port: dcache first,
// with a bounded dcache streak so a pending icache request is eventually served.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] icount,
    output logic [CNT_W-1:0] dcount,
    output logic [CNT_W-1:0] errcount
);
    typedef enum logic [1:0] {IDLE = 2'd0, DSERV = 2'd1, ISERV = 2'd2} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    state_t                state_reg;
    state_t                state_next;
    logic [STREAK_W-1:0]   dstreak_reg;
    logic [STREAK_W-1:0]   dstreak_next;
    logic [CNT_W-1:0]      errcount_reg;
    logic                  d_req;
    logic                  d_done;
    logic                  i_done;
    logic                  err_seen;
    logic [1:0]            done_vec;
    logic [1:0][CNT_W-1:0] xfer_cnt;

    assign d_req = bus.dren | bus.dwen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            dstreak_reg <= '0;
        end else begin
            state_reg   <= state_next;
            dstreak_reg <= dstreak_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dstreak_next = dstreak_reg;
        case (state_reg)
            IDLE: begin
                if (bus.iren && (dstreak_reg == STREAK_MAX)) state_next = ISERV;
                else if (d_req)                              state_next = DSERV;
                else if (bus.iren)                           state_next = ISERV;
            end
            // A withdrawn request abandons the transfer without completing it.
            DSERV:   if (!d_req || d_done)     state_next = IDLE;
            ISERV:   if (!bus.iren || i_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // The streak only grows while the icache is actually waiting.
        if (d_done) begin
            if (!bus.iren)                    dstreak_next = '0;
            else if (dstreak_reg != STREAK_MAX) dstreak_next = dstreak_reg + STREAK_W'(1);
        end
        if (i_done) dstreak_next = '0;
    end

    always_comb begin
        bus.ramren   = 1'b0;
        bus.ramwen   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        d_done       = 1'b0;
        i_done       = 1'b0;
        err_seen     = 1'b0;
        case (state_reg)
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramwen   = bus.dwen;
                bus.ramren   = bus.dren & ~bus.dwen;
                d_done       = d_req && (bus.ramstate == RAM_ACCESS);
                err_seen     = d_req && (bus.ramstate == RAM_ERROR);
                bus.dwait    = ~d_done;
                bus.dload    = d_done ? bus.ramload : '0;
            end
            ISERV: begin
                bus.ramaddr = bus.iaddr;
                bus.ramren  = bus.iren;
                i_done      = bus.iren && (bus.ramstate == RAM_ACCESS);
                err_seen    = bus.iren && (bus.ramstate == RAM_ERROR);
                bus.iwait   = ~i_done;
                bus.iload   = i_done ? bus.ramload : '0;
            end
            default: ;
        endcase
    end

    // Index 0 counts icache completions, index 1 dcache completions.
    assign done_vec = {d_done, i_done};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_xfer_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)               cnt_reg <= '0;
                else if (done_vec[gi]) cnt_reg <= cnt_reg + CNT_W'(1);
            end
            assign xfer_cnt[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 errcount_reg <= '0;
        else if (err_seen && (errcount_reg != '1)) errcount_reg <= errcount_reg + CNT_W'(1);
    end

    assign icount   = xfer_cnt[0];
    assign dcount   = xfer_cnt[1];
    assign errcount = errcount_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected completions are queued when a
// request is issued and popped when the arbiter drops iwait/dwait.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] icount, dcount, errcount;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_DSTREAK(4), .CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .icount   (icount),
        .dcount   (dcount),
        .errcount (errcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic clear_inputs();
        bus.iren = 0; bus.iaddr = '0; bus.dren = 0; bus.dwen = 0;
        bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = 2'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.iren = 1; bus.dren = 1; bus.ramstate = 2'd2; bus.ramload = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.ramren, bus.ramwen, bus.ramaddr, bus.ramstore, bus.iwait, bus.dwait, bus.iload, bus.dload}
            !== {2'b00, 64'h0, 2'b11, 64'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: ren=%b wen=%b addr=%h iwait=%b dwait=%b iload=%h dload=%h, want 0 0 0 1 1 0 0",
                     bus.ramren, bus.ramwen, bus.ramaddr, bus.iwait, bus.dwait, bus.iload, bus.dload);
        end
        vectors++;
        if ({icount, dcount, errcount} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", icount, dcount, errcount);
        end
        $display("reset: outputs and counters observed");
        clear_inputs();
        #1 rst = 1'b0;
    endtask

    task automatic test_read_latency();
        exp_t e;
        logic exp_ren;
        apply_reset();
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            bus.dren = 1; bus.daddr = 32'h40; bus.ramload = 32'hDEAD_BEEF;
            bus.ramstate = (c == 3) ? 2'd2 : ((c == 0) ? 2'd0 : 2'd1);
            @(negedge clk);
            exp_ren = (c != 0);
            vectors++;
            if ({bus.ramren, bus.ramaddr, bus.dwait, bus.iwait} !== {exp_ren, exp_ren ? 32'h40 : 32'h0, c != 3, 1'b1}) begin
                miscompares++;
                $display("FAIL read_cyc%0d: ren=%b addr=%h dwait=%b iwait=%b want ren=%b dwait=%b",
                         c, bus.ramren, bus.ramaddr, bus.dwait, bus.iwait, exp_ren, c != 3);
            end
            if (!bus.dwait || !bus.iwait) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL read_extra_done: cyc %0d", c);
                end else begin
                    e = sb.pop_front();
                    if ({!bus.dwait, bus.dload} !== {e.is_d, e.data}) begin
                        miscompares++;
                        $display("FAIL read_data: got d=%b %h want d=%b %h", !bus.dwait, bus.dload, e.is_d, e.data);
                    end
                end
            end
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (dcount !== 32'd1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL read_count: dcount=%0d pending=%0d want 1/0", dcount, sb.size());
        end
        $display("read_latency: dcache read done, dcount=%0d", dcount);
    endtask

    task automatic test_priority();
        exp_t        e;
        logic [3:0]  wen_t   = 4'b0010;
        logic [3:0]  ren_t   = 4'b1000;
        logic [31:0] addr_t  [4] = '{32'h0, 32'h80, 32'h0, 32'h100};
        logic [31:0] store_t [4] = '{32'h0, 32'h1234, 32'h0, 32'h0};
        apply_reset();
        sb.push_back('{1'b1, 32'h1111_0001});
        sb.push_back('{1'b0, 32'h1111_0003});
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            bus.iren = 1; bus.iaddr = 32'h100;
            bus.dwen = (c < 2); bus.daddr = 32'h80; bus.dstore = 32'h1234;
            bus.ramstate = 2'd2; bus.ramload = 32'h1111_0000 + c;
            @(negedge clk);
            vectors++;
            if ({bus.ramwen, bus.ramren, bus.ramaddr, bus.ramstore} !== {wen_t[c], ren_t[c], addr_t[c], store_t[c]}) begin
                miscompares++;
                $display("FAIL prio_cyc%0d: wen=%b ren=%b addr=%h store=%h want %b %b %h %h", c, bus.ramwen,
                         bus.ramren, bus.ramaddr, bus.ramstore, wen_t[c], ren_t[c], addr_t[c], store_t[c]);
            end
            if (!bus.dwait || !bus.iwait) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL prio_extra_done: cyc %0d", c);
                end else begin
                    e = sb.pop_front();
                    if ({!bus.dwait, !bus.iwait, !bus.dwait ? bus.dload : bus.iload} !== {e.is_d, !e.is_d, e.data}) begin
                        miscompares++;
                        $display("FAIL prio_done_cyc%0d: got dwait=%b iwait=%b data=%h want d=%b %h",
                                 c, bus.dwait, bus.iwait, !bus.dwait ? bus.dload : bus.iload, e.is_d, e.data);
                    end
                end
            end
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if ({icount, dcount} !== {32'd1, 32'd1} || sb.size() != 0) begin
            miscompares++;
            $display("FAIL prio_counts: icount=%0d dcount=%0d pending=%0d want 1/1/0", icount, dcount, sb.size());
        end
        $display("priority: write then fetch, icount=%0d dcount=%0d", icount, dcount);
    endtask

    task automatic test_starvation();
        exp_t e;
        logic got_d;
        int   cyc = 0;
        apply_reset();
        // Completions land on every odd cycle: four dcache then one icache, twice.
        for (int k = 0; k < 10; k++) sb.push_back('{(k % 5) != 4, 32'h5000_0000 + 32'(2 * k + 1)});
        while (sb.size() != 0 && cyc < 40) begin
            next_cycle();
            bus.iren = 1; bus.iaddr = 32'h1000; bus.dren = 1; bus.daddr = 32'h2000;
            bus.ramstate = 2'd2; bus.ramload = 32'h5000_0000 + 32'(cyc);
            @(negedge clk);
            if (!bus.dwait || !bus.iwait) begin
                vectors++;
                got_d = !bus.dwait;
                e = sb.pop_front();
                if ({bus.dwait, bus.iwait} == 2'b00 ||
                    {got_d, got_d ? bus.dload : bus.iload, bus.ramaddr} !== {e.is_d, e.data, e.is_d ? 32'h2000 : 32'h1000}) begin
                    miscompares++;
                    $display("FAIL streak_cyc%0d: dwait=%b iwait=%b data=%h addr=%h want d=%b %h",
                             cyc, bus.dwait, bus.iwait, got_d ? bus.dload : bus.iload, bus.ramaddr, e.is_d, e.data);
                end
            end
            cyc++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL streak_timeout: %0d completions missing", sb.size());
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if ({dcount, icount} !== {32'd8, 32'd2}) begin
            miscompares++;
            $display("FAIL streak_counts: dcount=%0d icount=%0d want 8/2", dcount, icount);
        end
        $display("starvation: %0d cycles, dcount=%0d icount=%0d", cyc, dcount, icount);
    endtask

    task automatic test_error();
        int   pulses = 0;
        logic exp_ren;
        apply_reset();
        sb.push_back('{1'b1, 32'hE4E4_0000});
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            bus.dren = 1; bus.daddr = 32'hC0; bus.ramload = 32'hE4E4_0000;
            bus.ramstate = (c == 0) ? 2'd0 : ((c == 4) ? 2'd2 : 2'd3);
            @(negedge clk);
            exp_ren = (c != 0);
            vectors++;
            if ({bus.ramren, bus.ramwen, bus.ramaddr, bus.dwait} !== {exp_ren, 1'b0, exp_ren ? 32'hC0 : 32'h0, c != 4}) begin
                miscompares++;
                $display("FAIL err_cyc%0d: ren=%b wen=%b addr=%h dwait=%b want ren=%b dwait=%b",
                         c, bus.ramren, bus.ramwen, bus.ramaddr, bus.dwait, exp_ren, c != 4);
            end
            if (!bus.dwait) begin
                pulses++;
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if ({errcount, dcount, 32'(pulses)} !== {32'd3, 32'd1, 32'd1} || sb.size() != 0) begin
            miscompares++;
            $display("FAIL err_counts: errcount=%0d dcount=%0d pulses=%0d want 3/1/1", errcount, dcount, pulses);
        end
        $display("error_retry: errcount=%0d dcount=%0d", errcount, dcount);
    endtask

    task automatic test_withdraw();
        exp_t e;
        logic [4:0] ren_t   = 5'b10010;
        logic [4:0] iwait_t = 5'b01111;
        apply_reset();
        sb.push_back('{1'b0, 32'h7777_0004});
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            bus.dren = (c < 2); bus.daddr = 32'h44;
            bus.iren = (c >= 3); bus.iaddr = 32'h200;
            bus.ramstate = (c < 3) ? 2'd1 : 2'd2; bus.ramload = 32'h7777_0000 + c;
            @(negedge clk);
            vectors++;
            if ({bus.ramren, bus.dwait, bus.iwait} !== {ren_t[c], 1'b1, iwait_t[c]}) begin
                miscompares++;
                $display("FAIL withdraw_cyc%0d: ren=%b dwait=%b iwait=%b want %b 1 %b",
                         c, bus.ramren, bus.dwait, bus.iwait, ren_t[c], iwait_t[c]);
            end
            if (!bus.iwait) begin
                vectors++;
                e = sb.pop_front();
                if ({bus.iload, bus.ramaddr} !== {e.data, 32'h200}) begin
                    miscompares++;
                    $display("FAIL withdraw_fetch: iload=%h addr=%h want %h 200", bus.iload, bus.ramaddr, e.data);
                end
            end
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if ({dcount, icount} !== {32'd0, 32'd1} || sb.size() != 0) begin
            miscompares++;
            $display("FAIL withdraw_counts: dcount=%0d icount=%0d pending=%0d want 0/1/0", dcount, icount, sb.size());
        end
        $display("withdraw: dcount=%0d icount=%0d", dcount, icount);
    endtask

    task automatic test_reset_mid();
        logic [3:0] iwait_t = 4'b1101;
        logic [3:0] ren_t   = 4'b1010;
        apply_reset();
        sb.push_back('{1'b0, 32'h3300_0001});
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            bus.iren = 1; bus.iaddr = 32'h300;
            bus.ramstate = (c < 2) ? 2'd2 : 2'd1; bus.ramload = 32'h3300_0000 + c;
            @(negedge clk);
            vectors++;
            if ({bus.ramren, bus.iwait} !== {ren_t[c], iwait_t[c]} || (!bus.iwait && bus.iload !== sb[0].data)) begin
                miscompares++;
                $display("FAIL rstmid_cyc%0d: ren=%b iwait=%b iload=%h want %b %b", c, bus.ramren, bus.iwait,
                         bus.iload, ren_t[c], iwait_t[c]);
            end
            if (!bus.iwait && sb.size() != 0) void'(sb.pop_front());
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.ramren, bus.ramaddr, bus.iwait, bus.iload, icount} !== {1'b0, 32'h0, 1'b1, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL rstmid_async: ren=%b addr=%h iwait=%b iload=%h icount=%0d want 0 0 1 0 0",
                     bus.ramren, bus.ramaddr, bus.iwait, bus.iload, icount);
        end
        next_cycle();
        rst = 1'b0;
        bus.ramstate = 2'd2; bus.ramload = 32'h3300_00AA;
        sb.push_back('{1'b0, 32'h3300_00AA});
        @(negedge clk);
        vectors++;
        if ({bus.ramren, bus.iwait} !== 2'b01) begin
            miscompares++;
            $display("FAIL rstmid_idle: ren=%b iwait=%b want 0 1", bus.ramren, bus.iwait);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({bus.ramren, bus.iwait, bus.iload} !== {1'b1, 1'b0, sb[0].data}) begin
            miscompares++;
            $display("FAIL rstmid_refetch: ren=%b iwait=%b iload=%h want 1 0 %h", bus.ramren, bus.iwait, bus.iload, sb[0].data);
        end
        if (!bus.iwait) void'(sb.pop_front());
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (icount !== 32'd1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_count: icount=%0d pending=%0d want 1/0", icount, sb.size());
        end
        $display("reset_mid_transfer: icount=%0d after refetch", icount);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_read_latency();
        test_priority();
        test_starvation();
        test_error();
        test_withdraw();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end
endmodule
